// File: rtl/em_pkg.sv
// Shared constants and types for the edit-memory buffer-request arbiter.
//   EM_NUM_REQ        default number of buffer-chain readers
//   EM_REQ_NBITS      requester-id width
//   EM_BUF_PTR_NBITS  linked-list buffer pointer width
//   EM_LL_ACK_LAT     cycles from buf_req to buf_ack_valid in the linked list
//   EM_MAX_OUT        default limit on outstanding linked-list requests
package em_pkg;
  localparam int EM_NUM_REQ       = 4;
  localparam int EM_REQ_NBITS     = $clog2(EM_NUM_REQ);
  localparam int EM_BUF_PTR_NBITS = 8;
  localparam int EM_LL_ACK_LAT    = 4;
  localparam int EM_MAX_OUT       = 8;

  typedef logic [EM_REQ_NBITS-1:0] em_req_id_t;
endpackage

// File: rtl/edit_mem_ack_tag_fifo.sv
// Flop FIFO holding the requester id of every request issued to the linked
// list, oldest at the head, so in-order acks can be routed back.
//   clk, rst_n    clock, asynchronous active-low reset (pointers/count only)
//   push_i        write push_data_i at the tail
//   pop_i         drop the head entry (ignored while empty)
//   push_data_i   requester id to store
//   head_o        oldest stored id (valid while !empty_o)
//   empty_o       no entries held
//   count_o       number of entries held (0..DEPTH)
module edit_mem_ack_tag_fifo #(
  parameter int  DEPTH = 8,
  parameter int  W     = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Storage is data only; a full FIFO may push and pop in one cycle because
  // the head is read before the edge that overwrites its slot.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (push_i && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/edit_mem_buf_req_arb.sv
// Shares the single buf_req/buf_ack port of the edit-memory linked list among
// NUM_REQ buffer-chain readers. Round-robin picks one request per cycle, the
// requester id is queued, and each in-order buf_ack is routed back to it.
//   req_valid/req_ptr     per-requester request and current pointer
//   req_ready             one-hot combinational grant
//   buf_req/buf_req_ptr   registered request to the linked list
//   buf_ack_valid/_ptr    linked-list response (in order)
//   ack_valid/ack_ptr     registered one-hot response to the requester
//   outstanding           issued requests not yet acked (<= MAX_OUT)
//   err_orphan_ack        sticky: ack arrived with no request outstanding
module edit_mem_buf_req_arb
  import em_pkg::*;
#(
  parameter int  NUM_REQ    = EM_NUM_REQ,
  parameter int  REQ_NBITS  = $clog2(NUM_REQ),
  parameter int  BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int  MAX_OUT    = EM_MAX_OUT,
  localparam int OUT_W      = $clog2(MAX_OUT) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BPTR_NBITS-1:0] req_ptr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            ack_valid,
  output logic [BPTR_NBITS-1:0]         ack_ptr,
  output logic                          buf_req,
  output logic [BPTR_NBITS-1:0]         buf_req_ptr,
  input  logic                          buf_ack_valid,
  input  logic [BPTR_NBITS-1:0]         buf_ack_ptr,
  output logic [OUT_W-1:0]              outstanding,
  output logic                          err_orphan_ack
);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  logic [REQ_NBITS-1:0]  rr_q, rr_d, pick_id, tag_head;
  logic                  pick_any, tag_empty, ack_pop, credit_ok, grant;
  logic [OUT_W-1:0]      tag_cnt, out_q, out_d;
  logic                  buf_req_q, err_q, err_d;
  logic [NUM_REQ-1:0]    ack_valid_q, ack_valid_d;
  logic [BPTR_NBITS-1:0] buf_req_ptr_q, ack_ptr_q, pick_ptr;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin : rr_pick
    int idx;
    pick_any = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!pick_any && req_valid[idx]) begin
        pick_any = 1'b1;
        pick_id  = REQ_NBITS'(idx);
      end
    end
  end

  assign pick_ptr = req_ptr[int'(pick_id)*BPTR_NBITS +: BPTR_NBITS];

  // An ack can only pop when a tag is queued; that same pop frees the credit
  // a grant needs when the queue is full.
  assign ack_pop   = buf_ack_valid && !tag_empty;
  assign credit_ok = (tag_cnt < MAX_OUT_C) || ack_pop;
  assign grant     = rst_n && pick_any && credit_ok;
  assign req_ready = grant ? (NUM_REQ'(1) << pick_id) : '0;

  edit_mem_ack_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (REQ_NBITS)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (grant),
    .pop_i       (ack_pop),
    .push_data_i (pick_id),
    .head_o      (tag_head),
    .empty_o     (tag_empty),
    .count_o     (tag_cnt)
  );

  always_comb begin
    rr_d        = rr_q;
    out_d       = out_q;
    ack_valid_d = '0;
    err_d       = err_q;
    if (grant) rr_d = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + 1'b1;
    if (grant && !ack_pop)      out_d = out_q + 1'b1;
    else if (!grant && ack_pop) out_d = out_q - 1'b1;
    if (ack_pop) ack_valid_d = NUM_REQ'(1) << tag_head;
    if (buf_ack_valid && tag_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      out_q       <= '0;
      buf_req_q   <= 1'b0;
      ack_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      out_q       <= out_d;
      buf_req_q   <= grant;
      ack_valid_q <= ack_valid_d;
      err_q       <= err_d;
    end
  end

  // Pointer registers are qualified by buf_req / ack_valid and carry no reset.
  always_ff @(posedge clk) begin
    if (grant)         buf_req_ptr_q <= pick_ptr;
    if (buf_ack_valid) ack_ptr_q     <= buf_ack_ptr;
  end

  assign buf_req        = buf_req_q;
  assign buf_req_ptr    = buf_req_ptr_q;
  assign ack_valid      = ack_valid_q;
  assign ack_ptr        = ack_ptr_q;
  assign outstanding    = out_q;
  assign err_orphan_ack = err_q;
endmodule

// File: tb/tb_edit_mem_buf_req_arb.sv
module tb_edit_mem_buf_req_arb;
  import em_pkg::*;

  localparam int NR = EM_NUM_REQ;
  localparam int PW = EM_BUF_PTR_NBITS;
  localparam int MO = EM_MAX_OUT;
  localparam int OW = $clog2(MO) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready, ack_valid;
  logic [NR*PW-1:0] req_ptr;
  logic [PW-1:0]    ack_ptr, buf_req_ptr, buf_ack_ptr;
  logic             buf_req, buf_ack_valid, err_orphan_ack;
  logic [OW-1:0]    outstanding;

  always #5 clk = ~clk;

  edit_mem_buf_req_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ptr        (req_ptr),
    .req_ready      (req_ready),
    .ack_valid      (ack_valid),
    .ack_ptr        (ack_ptr),
    .buf_req        (buf_req),
    .buf_req_ptr    (buf_req_ptr),
    .buf_ack_valid  (buf_ack_valid),
    .buf_ack_ptr    (buf_ack_ptr),
    .outstanding    (outstanding),
    .err_orphan_ack (err_orphan_ack)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: requester agents, linked-list responder, and the
  // expected registered outputs derived from the arbitration rules.
  typedef struct {
    int            due;
    logic [PW-1:0] val;
  } ll_t;

  int            cyc = 0;
  int            rr_m;
  int            tagq[$];
  bit            pend[NR];
  logic [PW-1:0] pptr[NR];
  int            req_prob = 0;
  ll_t           llq[$];
  bit            ll_stall = 0;
  bit            force_en = 0;
  logic [PW-1:0] force_val = '0;

  bit            e_breq;
  logic [PW-1:0] e_bptr;
  logic [NR-1:0] e_ackv;
  logic [PW-1:0] e_ackp;
  int            e_out;
  bit            e_err;

  int            dgr[$];
  int            dak[$];
  int            t_gnt, t_ack;
  logic [PW-1:0] s_bptr, s_ackp;

  function automatic int oh2i(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_clear();
    tagq.delete();
    rr_m   = 0;
    e_breq = 0;
    e_ackv = '0;
    e_out  = 0;
    e_err  = 0;
    for (int i = 0; i < NR; i++) pend[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && ($urandom_range(99) < 32'(req_prob))) begin
        pend[i] = 1;
        pptr[i] = PW'($urandom);
      end
      req_valid[i] = pend[i];
      req_ptr[i*PW +: PW] = pend[i] ? pptr[i] : PW'($urandom);
    end
    buf_ack_valid = 1'b0;
    buf_ack_ptr   = PW'($urandom);
    if (rst_n && !ll_stall && llq.size() > 0 && llq[0].due <= cyc) begin
      buf_ack_valid = 1'b1;
      buf_ack_ptr   = llq[0].val;
      llq.delete(0);
    end
  endtask

  task automatic step_model();
    int g;
    bit ack;
    bit credit;
    int t;
    g   = -1;
    ack = (buf_ack_valid === 1'b1);
    credit = (tagq.size() < MO) || (ack && tagq.size() > 0);
    if (rst_n && credit)
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (rr_m + k) % NR;
        if (g < 0 && pend[idx]) g = idx;
      end

    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("buf_req", 32'(buf_req), 32'(e_breq));
    if (e_breq) chk("buf_req_ptr", 32'(buf_req_ptr), 32'(e_bptr));
    chk("ack_valid", 32'(ack_valid), 32'(e_ackv));
    if (e_ackv != '0) chk("ack_ptr", 32'(ack_ptr), 32'(e_ackp));
    chk("outstanding", 32'(outstanding), 32'(e_out));
    chk("err_orphan_ack", 32'(err_orphan_ack), 32'(e_err));

    if (req_ready != '0) dgr.push_back(oh2i(req_ready));
    if (ack_valid != '0) dak.push_back(oh2i(ack_valid));
    if (req_ready == NR'(2)) t_gnt = cyc;
    if (ack_valid == NR'(2)) begin t_ack = cyc; s_ackp = ack_ptr; end
    if (buf_req === 1'b1) begin
      s_bptr = buf_req_ptr;
      llq.push_back('{due: cyc + EM_LL_ACK_LAT, val: force_en ? force_val : PW'($urandom)});
    end

    if (rst_n) begin
      e_breq = (g >= 0);
      if (g >= 0) e_bptr = pptr[g];
      e_ackv = '0;
      if (ack) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          e_ackv = NR'(1) << t;
          e_ackp = buf_ack_ptr;
        end else begin
          e_err = 1;
        end
      end
      if (g >= 0) begin
        tagq.push_back(g);
        rr_m = (g + 1) % NR;
        pend[g] = 0;
      end
      e_out = tagq.size();
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    step_model();
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b0;
    req_prob = 0;
    model_clear();
    drive();
    @(negedge clk);
    step_model();
    repeat (n - 1) cycle();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    drive();
    @(negedge clk);
    step_model();
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_ptr       = '0;
    buf_ack_valid = 1'b0;
    buf_ack_ptr   = '0;
    model_clear();
    for (int i = 0; i < NR; i++) pptr[i] = '0;
    e_bptr = '0;
    e_ackp = '0;
    t_gnt = -100;
    t_ack = -100;

    do_reset(3);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);

    // Orphan ack straight after reset.
    llq.push_back('{due: cyc, val: 8'h5A});
    repeat (3) cycle();
    chk("orphan_err", 32'(err_orphan_ack), 32'd1);
    chk("orphan_out", 32'(outstanding), 32'd0);
    repeat (4) cycle();
    chk("orphan_sticky", 32'(err_orphan_ack), 32'd1);

    // Single request from requester 1.
    force_en = 1;
    force_val = 8'h34;
    pend[1] = 1;
    pptr[1] = 8'h12;
    repeat (10) cycle();
    force_en = 0;
    chk("single_bptr", 32'(s_bptr), 32'h12);
    chk("single_ackp", 32'(s_ackp), 32'h34);
    chk("single_lat", 32'(t_ack - t_gnt), 32'd6);

    // Fairness: all requesters continuously valid.
    dgr.delete();
    dak.delete();
    req_prob = 100;
    repeat (16) cycle();
    chk("fair_ngrant", 32'(dgr.size() >= 12), 32'd1);
    for (int k = 1; k < 12 && k < dgr.size(); k++)
      chk("fair_order", 32'(dgr[k]), 32'((dgr[0] + k) % NR));
    chk("fair_nack", 32'(dak.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < dak.size(); k++)
      chk("fair_ack_route", 32'(dak[k]), 32'(dgr[k]));
    req_prob = 0;
    repeat (10) cycle();

    // Credit limit with acks withheld.
    ll_stall = 1;
    req_prob = 100;
    repeat (12) cycle();
    chk("credit_out", 32'(outstanding), 32'(MO));
    chk("credit_ready", 32'(req_ready), 32'd0);
    ll_stall = 0;
    cycle();
    chk("credit_release", 32'($countones(req_ready)), 32'd1);
    cycle();
    chk("credit_hold", 32'(outstanding), 32'(MO));
    repeat (6) cycle();

    // Randomised traffic with irregular ack gaps.
    req_prob = 40;
    for (int n = 0; n < 1500; n++) begin
      ll_stall = ($urandom_range(9) < 3);
      if ((n % 200) > 150) req_prob = 90;
      else req_prob = 40;
      cycle();
    end
    ll_stall = 0;
    req_prob = 0;
    repeat (30) cycle();
    chk("drain_out", 32'(outstanding), 32'd0);

    // Reset with 5 outstanding; late acks become orphans.
    ll_stall = 1;
    req_prob = 100;
    for (int k = 0; k < 20 && tagq.size() < 5; k++) cycle();
    req_prob = 0;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    cycle();
    chk("mid_out5", 32'(outstanding), 32'd5);
    do_reset(2);
    chk("mid_rst_err", 32'(err_orphan_ack), 32'd0);
    chk("mid_rst_out", 32'(outstanding), 32'd0);
    ll_stall = 0;
    repeat (8) cycle();
    chk("mid_orphan_err", 32'(err_orphan_ack), 32'd1);
    chk("mid_orphan_out", 32'(outstanding), 32'd0);
    req_prob = 30;
    repeat (40) cycle();
    req_prob = 0;
    repeat (12) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
